// File: rtl/saturating_alu_acc.sv
// Pipelined saturating add/sub/accumulate unit with valid/ready handshakes.
// Optional saturation event counter enabled by defining SAT_EVENT_CNT_EN.
module saturating_alu_acc #(
    parameter int WIDTH  = 8,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sat_hi,
    output logic             out_sat_lo,
    output logic             sticky_sat,
    output logic [WIDTH-1:0] acc_q
`ifdef SAT_EVENT_CNT_EN
    ,
    output logic [15:0]      sat_cnt
`endif
);

    localparam logic [WIDTH-1:0] MAXV = (SIGNED != 0) ? {1'b0, {(WIDTH-1){1'b1}}} : {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] MINV = (SIGNED != 0) ? {1'b1, {(WIDTH-1){1'b0}}} : {WIDTH{1'b0}};

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic             r_sat_hi;
    logic             r_sat_lo;
    logic             r_sticky;
    logic [WIDTH-1:0] r_acc;

    logic             w_xfer;
    logic [WIDTH-1:0] w_acc_eff;
    logic [WIDTH-1:0] w_op1;
    logic [WIDTH-1:0] w_op2;
    logic [WIDTH:0]   w_op1_x;
    logic [WIDTH:0]   w_op2_x;
    logic [WIDTH:0]   w_sum;
    logic             w_hi;
    logic             w_lo;
    logic [WIDTH-1:0] w_res;

    assign in_ready  = !r_out_valid || out_ready;
    assign w_xfer    = in_valid && in_ready;
    // A clear in the same cycle as an accumulate makes the operation see zero.
    assign w_acc_eff = clr ? '0 : r_acc;
    assign w_op1     = in_mode[1] ? w_acc_eff : in_a;
    assign w_op2     = in_mode[1] ? in_a : in_b;

    always_comb begin
        w_op1_x = {1'b0, w_op1};
        w_op2_x = {1'b0, w_op2};
        if (SIGNED != 0) begin
            w_op1_x = {w_op1[WIDTH-1], w_op1};
            w_op2_x = {w_op2[WIDTH-1], w_op2};
        end
    end

    assign w_sum = in_mode[0] ? (w_op1_x - w_op2_x) : (w_op1_x + w_op2_x);

    // Unsigned: the extra bit is a carry on add and a borrow on subtract.
    // Signed: the extra bit disagreeing with the MSB means out of range, its value gives direction.
    always_comb begin
        w_hi = 1'b0;
        w_lo = 1'b0;
        if (SIGNED != 0) begin
            w_hi = (w_sum[WIDTH] != w_sum[WIDTH-1]) && !w_sum[WIDTH];
            w_lo = (w_sum[WIDTH] != w_sum[WIDTH-1]) &&  w_sum[WIDTH];
        end else begin
            w_hi = w_sum[WIDTH] && !in_mode[0];
            w_lo = w_sum[WIDTH] &&  in_mode[0];
        end
    end

    always_comb begin
        w_res = w_sum[WIDTH-1:0];
        if (w_hi)      w_res = MAXV;
        else if (w_lo) w_res = MINV;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_sat_hi    <= 1'b0;
            r_sat_lo    <= 1'b0;
            r_sticky    <= 1'b0;
            r_acc       <= '0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_res;
                r_sat_hi    <= w_hi;
                r_sat_lo    <= w_lo;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

            if (w_xfer)   r_acc <= w_res;
            else if (clr) r_acc <= '0;

            if (w_xfer && (w_hi || w_lo)) r_sticky <= 1'b1;
            else if (clr)                 r_sticky <= 1'b0;
        end
    end

`ifdef SAT_EVENT_CNT_EN
    logic [15:0] r_sat_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sat_cnt <= '0;
        end else if (w_xfer && (w_hi || w_lo)) begin
            if (clr)                      r_sat_cnt <= 16'd1;
            else if (r_sat_cnt != 16'hFFFF) r_sat_cnt <= r_sat_cnt + 16'd1;
        end else if (clr) begin
            r_sat_cnt <= '0;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

    assign out_valid  = r_out_valid;
    assign out_data   = r_out_data;
    assign out_sat_hi = r_sat_hi;
    assign out_sat_lo = r_sat_lo;
    assign sticky_sat = r_sticky;
    assign acc_q      = r_acc;

endmodule
